// File: rtl/stream_bcd_packer.sv
// Streaming binary-to-decimal packer: captures one word, converts it serially with
// double-dabble, then emits its digits MSB-first as bytes with packet framing.
module stream_bcd_packer #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned ASCII       = 1,
  parameter int unsigned SUPPRESS_LZ = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_tdata,
  input  logic              i_tdata_valid,
  input  logic              i_tdata_last,
  output logic              o_tready,
  output logic [7:0]        o_tanswer_data,
  output logic              o_tanswer_ready,
  output logic              o_tanswer_data_last,
  input  logic              i_tmanager_ready,
  output logic [11:0]       o_packet_size_in_bytes
);

  // Smallest decimal digit count able to hold every DATA_W-bit value.
  function automatic int unsigned min_digits(input int unsigned w);
    int unsigned      d;
    longint unsigned  v;
    longint unsigned  lim;
    d   = 0;
    v   = 64'd1;
    lim = 64'd1 << w;
    for (int i = 0; i < 8; i++) begin
      if (v < lim) begin
        v = v * 64'd10;
        d = d + 1;
      end
    end
    return d;
  endfunction

  generate
    if (DATA_W < 4 || DATA_W > 16 || DIGITS < min_digits(DATA_W)) begin : g_bad_params
      $error("stream_bcd_packer: DATA_W must be 4..16 and DIGITS large enough for DATA_W");
    end
  endgenerate

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam int unsigned BCD_W = DIGITS * 4;

  typedef enum logic [1:0] {IDLE, CONVERT, EMIT} state_t;

  state_t                        state_q, state_d;
  logic                          tready_q, tready_d;
  logic [7:0]                    data_q, data_d;
  logic                          valid_q, valid_d;
  logic                          last_q, last_d;
  logic [11:0]                   size_q, size_d;
  logic [11:0]                   cnt_q, cnt_d;
  logic [DATA_W-1:0]             sr_q, sr_d;
  logic [DIGITS-1:0][3:0]        bcd_q, bcd_d;
  logic [BIT_W-1:0]              bit_q, bit_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic                          wlast_q, wlast_d;

  logic [DIGITS-1:0][3:0]        adj;
  logic [BCD_W-1:0]              adj_flat;
  logic [IDX_W-1:0]              start_idx;
  logic [11:0]                   cnt_inc;

  function automatic logic [7:0] to_byte(input logic [3:0] d);
    return (ASCII != 0) ? (8'h30 + {4'h0, d}) : {4'h0, d};
  endfunction

  // Double-dabble add-3 correction applied before each shift.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      adj[i] = (bcd_q[i] >= 4'd5) ? (bcd_q[i] + 4'd3) : bcd_q[i];
    end
  end
  assign adj_flat = adj;

  // First digit to emit: most significant nonzero digit, or digit 0 for a zero value.
  always_comb begin
    start_idx = '0;
    if (SUPPRESS_LZ == 0) begin
      start_idx = IDX_W'(DIGITS - 1);
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (bcd_q[i] != 4'd0) start_idx = IDX_W'(i);
      end
    end
  end

  assign cnt_inc = (cnt_q == 12'hFFF) ? cnt_q : (cnt_q + 12'd1);

  always_comb begin
    state_d  = state_q;
    tready_d = 1'b0;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    bcd_d    = bcd_q;
    bit_d    = bit_q;
    idx_d    = idx_q;
    wlast_d  = wlast_q;
    case (state_q)
      IDLE: begin
        tready_d = 1'b1;
        if (i_tdata_valid && tready_q) begin
          sr_d     = i_tdata;
          wlast_d  = i_tdata_last;
          bcd_d    = '0;
          bit_d    = '0;
          tready_d = 1'b0;
          state_d  = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d = {adj_flat[BCD_W-2:0], sr_q[DATA_W-1]};
        sr_d  = {sr_q[DATA_W-2:0], 1'b0};
        bit_d = bit_q + BIT_W'(1);
        if (bit_q == BIT_W'(DATA_W - 1)) state_d = EMIT;
      end
      EMIT: begin
        if (!valid_q) begin
          idx_d   = start_idx;
          valid_d = 1'b1;
          data_d  = to_byte(bcd_q[start_idx]);
          last_d  = wlast_q && (start_idx == '0);
        end else if (i_tmanager_ready) begin
          if (last_q) begin
            size_d = cnt_inc;
            cnt_d  = '0;
          end else begin
            cnt_d  = cnt_inc;
          end
          if (idx_q == '0) begin
            valid_d  = 1'b0;
            data_d   = 8'h00;
            last_d   = 1'b0;
            tready_d = 1'b1;
            state_d  = IDLE;
          end else begin
            idx_d  = idx_q - IDX_W'(1);
            data_d = to_byte(bcd_q[idx_q - IDX_W'(1)]);
            last_d = wlast_q && (idx_q == IDX_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      tready_q <= 1'b0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      size_q   <= '0;
      cnt_q    <= '0;
      sr_q     <= '0;
      bcd_q    <= '0;
      bit_q    <= '0;
      idx_q    <= '0;
      wlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tready_q <= tready_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      bcd_q    <= bcd_d;
      bit_q    <= bit_d;
      idx_q    <= idx_d;
      wlast_q  <= wlast_d;
    end
  end

  assign o_tready               = tready_q;
  assign o_tanswer_data         = data_q;
  assign o_tanswer_ready        = valid_q;
  assign o_tanswer_data_last    = last_q;
  assign o_packet_size_in_bytes = size_q;

endmodule

// File: tb/tb_stream_bcd_packer.sv
// Bench for stream_bcd_packer: three parameterisations driven by directed vectors,
// plus a randomly back-pressured run against a decimal reference model.
module tb_stream_bcd_packer;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [15:0]      tdata;
  logic             tlast;
  logic [2:0]       tvalid;
  logic [2:0]       mready;
  logic [2:0]       tready;
  logic [2:0]       ovalid;
  logic [2:0]       olast;
  logic [2:0][7:0]  odata;
  logic [2:0][11:0] psize;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [7:0] mq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_bcd_packer u_def (
    .i_clk(clk), .i_rst(rst_n), .i_tdata(tdata[7:0]), .i_tdata_valid(tvalid[0]),
    .i_tdata_last(tlast), .o_tready(tready[0]), .o_tanswer_data(odata[0]),
    .o_tanswer_ready(ovalid[0]), .o_tanswer_data_last(olast[0]),
    .i_tmanager_ready(mready[0]), .o_packet_size_in_bytes(psize[0]));

  stream_bcd_packer #(.ASCII(0), .SUPPRESS_LZ(0)) u_raw (
    .i_clk(clk), .i_rst(rst_n), .i_tdata(tdata[7:0]), .i_tdata_valid(tvalid[1]),
    .i_tdata_last(tlast), .o_tready(tready[1]), .o_tanswer_data(odata[1]),
    .o_tanswer_ready(ovalid[1]), .o_tanswer_data_last(olast[1]),
    .i_tmanager_ready(mready[1]), .o_packet_size_in_bytes(psize[1]));

  stream_bcd_packer #(.DATA_W(16), .DIGITS(5)) u_wide (
    .i_clk(clk), .i_rst(rst_n), .i_tdata(tdata), .i_tdata_valid(tvalid[2]),
    .i_tdata_last(tlast), .o_tready(tready[2]), .o_tanswer_data(odata[2]),
    .o_tanswer_ready(ovalid[2]), .o_tanswer_data_last(olast[2]),
    .i_tmanager_ready(mready[2]), .o_packet_size_in_bytes(psize[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic send_word(input int k, input logic [15:0] w, input logic l);
    int waited = 0;
    forever begin
      @(negedge clk);
      if (tready[k]) break;
      waited++;
      if (waited > 200) begin
        check("accept_timeout", 32'(tready[k]), 32'd1);
        return;
      end
    end
    tdata     = w;
    tlast     = l;
    tvalid[k] = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    tvalid[k] = 1'b0;
  endtask

  // Collect bytes of one word; rnd randomises consumer ready; lat>0 checks first-byte latency.
  task automatic recv_word(input int k, input logic [7:0] exp_b[$], input logic exp_last,
                           input bit rnd, input int lat);
    int waited;
    bit held;
    bit seen;
    logic [7:0] hd;
    logic hl;
    seen = 0;
    for (int b = 0; b < exp_b.size(); b++) begin
      waited = 0;
      held   = 0;
      forever begin
        @(negedge clk);
        if (waited == 0) check("tready_busy", 32'(tready[k]), 32'd0);
        if (ovalid[k] && held) begin
          check("hold_data", 32'(odata[k]), 32'(hd));
          check("hold_last", 32'(olast[k]), 32'(hl));
        end
        if (ovalid[k] && !seen) begin
          seen = 1;
          if (lat > 0) check("latency", 32'(cyc - acc_cyc), 32'(lat));
        end
        mready[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (ovalid[k] && mready[k]) break;
        held = ovalid[k];
        hd   = odata[k];
        hl   = olast[k];
        waited++;
        if (waited > 500) begin
          check("byte_timeout", 32'(ovalid[k]), 32'd1);
          return;
        end
      end
      check("data", 32'(odata[k]), 32'(exp_b[b]));
      check("last", 32'(olast[k]), 32'(exp_last && (b == exp_b.size() - 1)));
    end
  endtask

  task automatic model_bytes(input int v);
    int x;
    x = v;
    mq.delete();
    if (x == 0) mq.push_back(8'h30);
    while (x > 0) begin
      mq.push_front(8'h30 + 8'(x % 10));
      x = x / 10;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] q[$];
    int exp_size;
    int nwords;
    int w;

    rst_n  = 1'b0;
    tdata  = '0;
    tlast  = 1'b0;
    tvalid = '0;
    mready = '0;
    #23;
    for (int k = 0; k < 3; k++) begin
      check("rst_tready", 32'(tready[k]), 32'd0);
      check("rst_valid", 32'(ovalid[k]), 32'd0);
      check("rst_last", 32'(olast[k]), 32'd0);
      check("rst_data", 32'(odata[k]), 32'd0);
      check("rst_size", 32'(psize[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("tready_pre_edge", 32'(tready[0]), 32'd0);
    @(posedge clk);
    #1 check("tready_post_edge", 32'(tready[0]), 32'd1);

    // Single word 205
    send_word(0, 16'd205, 1'b1);
    q = '{8'h32, 8'h30, 8'h35};
    recv_word(0, q, 1'b1, 1'b0, 9);
    @(negedge clk);
    check("size_205", 32'(psize[0]), 32'd3);
    check("idle_valid", 32'(ovalid[0]), 32'd0);
    check("idle_data", 32'(odata[0]), 32'd0);

    // Packet 7, 0, 255
    send_word(0, 16'd7, 1'b0);
    q = '{8'h37};
    recv_word(0, q, 1'b0, 1'b0, 9);
    send_word(0, 16'd0, 1'b0);
    q = '{8'h30};
    recv_word(0, q, 1'b0, 1'b0, 9);
    check("size_hold", 32'(psize[0]), 32'd3);
    send_word(0, 16'd255, 1'b1);
    q = '{8'h32, 8'h35, 8'h35};
    recv_word(0, q, 1'b1, 1'b0, 9);
    @(negedge clk);
    check("size_pkt5", 32'(psize[0]), 32'd5);

    // Raw digits, no suppression
    send_word(1, 16'd9, 1'b1);
    q = '{8'h00, 8'h00, 8'h09};
    recv_word(1, q, 1'b1, 1'b0, 9);
    @(negedge clk);
    check("size_raw", 32'(psize[1]), 32'd3);

    // 16-bit maximum
    send_word(2, 16'd65535, 1'b1);
    q = '{8'h36, 8'h35, 8'h35, 8'h33, 8'h35};
    recv_word(2, q, 1'b1, 1'b0, 17);
    @(negedge clk);
    check("size_wide", 32'(psize[2]), 32'd5);

    // Random back-pressure against the decimal model
    exp_size = 5;
    for (int p = 0; p < 100; p++) begin
      check("size_hold_rnd", 32'(psize[0]), 32'(exp_size));
      nwords   = $urandom_range(1, 3);
      exp_size = 0;
      for (int i = 0; i < nwords; i++) begin
        w = $urandom_range(0, 255);
        if ($urandom_range(0, 7) == 0) w = 0;
        model_bytes(w);
        exp_size += mq.size();
        send_word(0, 16'(w), 1'(i == nwords - 1));
        recv_word(0, mq, 1'(i == nwords - 1), 1'b1, 9);
      end
      @(negedge clk);
      mready[0] = 1'($urandom_range(0, 1));
      check("size_rnd", 32'(psize[0]), 32'(exp_size));
    end

    // Reset during second digit of EMIT
    mready[0] = 1'b1;
    send_word(0, 16'd205, 1'b1);
    q = '{8'h32};
    recv_word(0, q, 1'b0, 1'b0, 9);
    @(negedge clk);
    mready[0] = 1'b0;
    check("second_digit", 32'(odata[0]), 32'h30);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ovalid[0]), 32'd0);
    check("mid_rst_data", 32'(odata[0]), 32'd0);
    check("mid_rst_last", 32'(olast[0]), 32'd0);
    check("mid_rst_tready", 32'(tready[0]), 32'd0);
    check("mid_rst_size", 32'(psize[0]), 32'd0);
    mready[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_hold_valid", 32'(ovalid[0]), 32'd0);
    rst_n = 1'b1;
    send_word(0, 16'd42, 1'b1);
    q = '{8'h34, 8'h32};
    recv_word(0, q, 1'b1, 1'b0, 9);
    @(negedge clk);
    check("size_after_rst", 32'(psize[0]), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
